// File: rtl/imem_dmem_loader.sv
`default_nettype none
// ============================================================================
// imem_dmem_loader : host writer for I_Mem/D_Mem; holds cpu_rst until RUN.
// Optional checksum: define LOADER_CKSUM_EN.         Revision: 1.0
// ============================================================================
module imem_dmem_loader #(
  parameter int IM_DEPTH = 9,
  parameter int DM_DEPTH = 8,
  parameter int I_WIDTH  = 32,
  parameter int D_WIDTH  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          cmd_i,
  input  logic [IM_DEPTH-1:0] cmd_base_i,
  input  logic [IM_DEPTH-1:0] cmd_len_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [I_WIDTH-1:0]  wdata_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic                imem_we_o,
  output logic [IM_DEPTH-1:0] imem_addr_o,
  output logic [I_WIDTH-1:0]  imem_din_o,
  output logic                dmem_we_o,
  output logic [DM_DEPTH-1:0] dmem_addr_o,
  output logic [D_WIDTH-1:0]  dmem_din_o,
  output logic                cpu_rst_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [I_WIDTH-1:0]  cksum_o
);

  localparam logic [1:0] C_HALT   = 2'd0;
  localparam logic [1:0] C_LOAD_I = 2'd1;
  localparam logic [1:0] C_LOAD_D = 2'd2;
  localparam logic [1:0] C_RUN    = 2'd3;
  localparam logic [IM_DEPTH-1:0] C_ONE = IM_DEPTH'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_I  = 3'd1,
    S_LOAD_D_LO = 3'd2,
    S_LOAD_D_HI = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [IM_DEPTH-1:0]  ptr_q, ptr_d;
  logic [IM_DEPTH-1:0]  rem_q, rem_d;
  logic [I_WIDTH-1:0]   lo_q, lo_d;
  logic                 imem_we_q, imem_we_d;
  logic [IM_DEPTH-1:0]  imem_addr_q, imem_addr_d;
  logic [I_WIDTH-1:0]   imem_din_q, imem_din_d;
  logic                 dmem_we_q, dmem_we_d;
  logic [DM_DEPTH-1:0]  dmem_addr_q, dmem_addr_d;
  logic [D_WIDTH-1:0]   dmem_din_q, dmem_din_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 cmd_fire, w_fire;

  assign cmd_ready_o = (state_q == S_IDLE) || (state_q == S_RUN);
  assign wready_o    = (state_q == S_LOAD_I) || (state_q == S_LOAD_D_LO) ||
                       (state_q == S_LOAD_D_HI);
  assign busy_o      = wready_o;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign w_fire      = wvalid_i && wready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      lo_q        <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_din_q  <= '0;
      dmem_we_q   <= 1'b0;
      dmem_addr_q <= '0;
      dmem_din_q  <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      lo_q        <= lo_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_din_q  <= imem_din_d;
      dmem_we_q   <= dmem_we_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_din_q  <= dmem_din_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    lo_d        = lo_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_din_d  = imem_din_q;
    dmem_we_d   = 1'b0;
    dmem_addr_d = dmem_addr_q;
    dmem_din_d  = dmem_din_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          ptr_d = cmd_base_i;
          rem_d = cmd_len_i;
          case (cmd_i)
            C_LOAD_I: begin
              if (cmd_len_i == '0) done_d = 1'b1;
              else                 state_d = S_LOAD_I;
            end
            C_LOAD_D: begin
              if (cmd_len_i == '0) done_d = 1'b1;
              else                 state_d = S_LOAD_D_LO;
            end
            C_RUN:   state_d = S_RUN;
            default: ;
          endcase
        end
      end
      S_LOAD_I: begin
        if (w_fire) begin
          imem_we_d   = 1'b1;
          imem_addr_d = ptr_q;
          imem_din_d  = wdata_i;
          ptr_d       = ptr_q + C_ONE;
          rem_d       = rem_q - C_ONE;
          if (rem_q == C_ONE) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_LOAD_D_LO: begin
        if (w_fire) begin
          lo_d    = wdata_i;
          state_d = S_LOAD_D_HI;
        end
      end
      S_LOAD_D_HI: begin
        if (w_fire) begin
          // Upper ptr bits are ignored so D_Mem addresses wrap at 2^DM_DEPTH.
          dmem_we_d   = 1'b1;
          dmem_addr_d = ptr_q[DM_DEPTH-1:0];
          dmem_din_d  = {wdata_i, lo_q};
          ptr_d       = ptr_q + C_ONE;
          rem_d       = rem_q - C_ONE;
          if (rem_q == C_ONE) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD_D_LO;
          end
        end
      end
      S_RUN: begin
        if (cmd_fire) begin
          if (cmd_i == C_HALT) state_d = S_IDLE;
          else                 err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_rst_d = (state_d != S_RUN);
  end

  assign imem_we_o   = imem_we_q;
  assign imem_addr_o = imem_addr_q;
  assign imem_din_o  = imem_din_q;
  assign dmem_we_o   = dmem_we_q;
  assign dmem_addr_o = dmem_addr_q;
  assign dmem_din_o  = dmem_din_q;
  assign cpu_rst_o   = cpu_rst_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

`ifdef LOADER_CKSUM_EN
  logic [I_WIDTH-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (cmd_fire)    cksum_d = '0;
    else if (w_fire) cksum_d = cksum_q ^ wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) cksum_q <= '0;
    else     cksum_q <= cksum_d;
  end

  assign cksum_o = cksum_q;
`else
  assign cksum_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_dmem_loader : directed vector bench for imem_dmem_loader.
// Revision: 1.0
// ============================================================================
module tb_imem_dmem_loader;

  localparam logic [1:0] C_HALT   = 2'd0;
  localparam logic [1:0] C_LOAD_I = 2'd1;
  localparam logic [1:0] C_LOAD_D = 2'd2;
  localparam logic [1:0] C_RUN    = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cmd = 2'd0;
  logic [8:0]  cmd_base = '0;
  logic [8:0]  cmd_len = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic        imem_we;
  logic [8:0]  imem_addr;
  logic [31:0] imem_din;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [63:0] dmem_din;
  logic        cpu_rst, busy, done, err;
  logic [31:0] cksum;

  imem_dmem_loader dut (
    .clk(clk), .rst(rst),
    .cmd_i(cmd), .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .wdata_i(wdata), .wvalid_i(wvalid), .wready_o(wready),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_din_o(imem_din),
    .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_din_o(dmem_din),
    .cpu_rst_o(cpu_rst), .busy_o(busy), .done_o(done), .err_o(err),
    .cksum_o(cksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [8:0]  im_a[$];
  logic [31:0] im_d[$];
  logic [7:0]  dm_a[$];
  logic [63:0] dm_d[$];
  int          done_cnt = 0;
  int          done_with_we = 0;
  logic [8:0]  done_im_addr = '0;
  int          overlap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin im_a.push_back(imem_addr); im_d.push_back(imem_din); end
    if (dmem_we) begin dm_a.push_back(dmem_addr); dm_d.push_back(dmem_din); end
    if (done) done_cnt++;
    if (done && imem_we) begin done_with_we++; done_im_addr = imem_addr; end
    if (imem_we && dmem_we) overlap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    im_a.delete(); im_d.delete(); dm_a.delete(); dm_d.delete();
    done_cnt = 0; done_with_we = 0; overlap = 0;
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [8:0] b, input logic [8:0] l);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    cmd = c; cmd_base = b; cmd_len = l; cmd_valid = 1'b1;
    while (!acc && n < 20) begin
      acc = cmd_ready;
      tick(1);
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      checks++; fails++;
      $display("FAIL cmd_accept: got timeout required accept");
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    wdata = w; wvalid = 1'b1;
    while (!acc && n < 20) begin
      acc = wready;
      tick(1);
      n++;
    end
    if (!acc) begin
      checks++; fails++;
      $display("FAIL word_accept: got timeout required accept");
    end
  endtask

  function automatic logic [31:0] ck(input logic [31:0] v);
`ifdef LOADER_CKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  base;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        is_d;
    logic [8:0]  exp_addr;
    logic [63:0] exp_din;
    logic [31:0] exp_ck;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t0;
    vecs[0] = '{C_LOAD_I, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, 9'h010, 64'h00000000_DEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{C_LOAD_I, 9'h1FF, 32'h12345678, 32'h0, 1'b0, 9'h1FF, 64'h00000000_12345678, 32'h12345678};
    vecs[2] = '{C_LOAD_D, 9'h005, 32'h11111111, 32'h22222222, 1'b1, 9'h005, 64'h22222222_11111111, 32'h33333333};
    vecs[3] = '{C_LOAD_D, 9'h1FF, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 9'h0FF, 64'h5A5A5A5A_A5A5A5A5, 32'hFFFFFFFF};
    vecs[4] = '{C_LOAD_D, 9'h000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 9'h000, 64'hFFFFFFFF_00000000, 32'hFFFFFFFF};

    // Reset state
    rst = 1'b1;
    tick(3);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wready", wready, 0);
    check("rst_cksum", cksum, 0);
    rst = 1'b0;
    tick(1);

    // Single-entry loads from the vector table
    for (int i = 0; i < 5; i++) begin
      clear_log();
      send_cmd(vecs[i].cmd, vecs[i].base, 9'd1);
      check($sformatf("v%0d_busy", i), busy, 1);
      send_word(vecs[i].lo);
      if (vecs[i].is_d) send_word(vecs[i].hi);
      wvalid = 1'b0;
      tick(3);
      check($sformatf("v%0d_im_cnt", i), im_a.size(), vecs[i].is_d ? 0 : 1);
      check($sformatf("v%0d_dm_cnt", i), dm_a.size(), vecs[i].is_d ? 1 : 0);
      if (vecs[i].is_d) begin
        check($sformatf("v%0d_dm_addr", i), dm_a[0], vecs[i].exp_addr);
        check($sformatf("v%0d_dm_din", i), dm_d[0], vecs[i].exp_din);
      end else begin
        check($sformatf("v%0d_im_addr", i), im_a[0], vecs[i].exp_addr);
        check($sformatf("v%0d_im_din", i), im_d[0], vecs[i].exp_din);
      end
      check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      check($sformatf("v%0d_cksum", i), cksum, ck(vecs[i].exp_ck));
      check($sformatf("v%0d_idle", i), cmd_ready, 1);
      check($sformatf("v%0d_overlap", i), overlap, 0);
    end

    // Zero-length load: done next cycle, no writes, stays idle
    clear_log();
    send_cmd(C_LOAD_I, 9'h040, 9'd0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    tick(2);
    check("len0_done_cnt", done_cnt, 1);
    check("len0_writes", im_a.size() + dm_a.size(), 0);

    // LOAD_I wrapping past the top of I_Mem, back-to-back words
    clear_log();
    send_cmd(C_LOAD_I, 9'h1FE, 9'd3);
    t0 = cyc;
    send_word(32'hAAAA0001);
    send_word(32'hBBBB0002);
    send_word(32'hCCCC0003);
    wvalid = 1'b0;
    check("wrap_rate_cycles", cyc - t0, 3);
    tick(3);
    check("wrap_cnt", im_a.size(), 3);
    check("wrap_a0", im_a[0], 9'h1FE);
    check("wrap_d0", im_d[0], 32'hAAAA0001);
    check("wrap_a1", im_a[1], 9'h1FF);
    check("wrap_d1", im_d[1], 32'hBBBB0002);
    check("wrap_a2", im_a[2], 9'h000);
    check("wrap_d2", im_d[2], 32'hCCCC0003);
    check("wrap_done_cnt", done_cnt, 1);
    check("wrap_done_with_we", done_with_we, 1);
    check("wrap_done_addr", done_im_addr, 9'h000);

    // Checksum over two words, cleared by the next command
    send_cmd(C_LOAD_I, 9'h020, 9'd2);
    send_word(32'hF0F0F0F0);
    send_word(32'h0FF00FF0);
    wvalid = 1'b0;
    check("cksum_value", cksum, ck(32'hFF00FF00));
    tick(1);
    send_cmd(C_HALT, 9'h0, 9'd0);
    check("cksum_cleared", cksum, 0);
    check("halt_idle_cpu_rst", cpu_rst, 1);

    // RUN, illegal load in RUN, HALT
    clear_log();
    send_cmd(C_RUN, 9'h0, 9'd0);
    check("run_cpu_rst", cpu_rst, 0);
    check("run_wready", wready, 0);
    send_cmd(C_LOAD_I, 9'h0, 9'd4);
    check("run_err", err, 1);
    check("run_cpu_rst_kept", cpu_rst, 0);
    check("run_stays", cmd_ready, 1);
    check("run_no_writes", im_a.size() + dm_a.size(), 0);
    send_cmd(C_HALT, 9'h0, 9'd0);
    check("halt_cpu_rst", cpu_rst, 1);
    check("err_sticky", err, 1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("err_cleared", err, 0);

    // Reset mid-load: only the completed D_Mem entry is written
    clear_log();
    send_cmd(C_LOAD_D, 9'h010, 9'd2);
    send_word(32'h01010101);
    send_word(32'h02020202);
    send_word(32'h03030303);
    wvalid = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("abort_dm_cnt", dm_a.size(), 1);
    check("abort_dm_addr", dm_a[0], 8'h10);
    check("abort_dm_din", dm_d[0], 64'h02020202_01010101);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_busy", busy, 0);
    check("abort_cpu_rst", cpu_rst, 1);
    check("abort_idle", cmd_ready, 1);
    // Stray words while idle are ignored
    wdata = 32'h5555AAAA;
    wvalid = 1'b1;
    tick(3);
    wvalid = 1'b0;
    tick(1);
    check("stray_err", err, 0);
    check("stray_writes", im_a.size() + dm_a.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
